// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment display scan controller.
package disp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } disp_state_e;

  localparam int NIBBLE_W   = 4;
  localparam int SEL_W      = 2;
  localparam int MAX_DIGITS = 4;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

endpackage

// File: rtl/disp_tick_cnt.sv
// Loadable down-counter for the scan slot timer; done flags the last cycle of a slot.
module disp_tick_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturates at zero so an unloaded counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == W'(1));

endmodule

// File: rtl/disp_scan_ctrl.sv
// Multiplexed digit scanner with frame-synchronous double-buffered nibbles.
// Optional leading-zero suppression is enabled by defining DISP_LZ_BLANK_EN.
//
//   state | meaning
//   IDLE  | scan stopped, anodes off, SEL=0; loads commit immediately
//   SHOW  | digit SEL lit for CLK_DIV cycles
//   BLANK | all anodes off for DEAD_CYC cycles before the next digit
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int CLK_DIV    = 4096,
  parameter int DEAD_CYC   = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           EN,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] D_IN,
  input  logic                           LOAD,
  output logic                           LOAD_ACK,
  output logic [SEL_W-1:0]               SEL,
  output logic [NUM_DIGITS-1:0]          AN,
  output logic [NIBBLE_W-1:0]            DIG,
  output logic                           FRAME
);

  localparam int CNT_MAX = (CLK_DIV > DEAD_CYC) ? CLK_DIV : DEAD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DATA_W  = NIBBLE_W * NUM_DIGITS;

  localparam logic [CNT_W-1:0]      SHOW_LEN = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0]      DEAD_LEN = CNT_W'(DEAD_CYC);
  localparam logic [SEL_W-1:0]      LAST_SEL = SEL_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = ANODE_OFF[NUM_DIGITS-1:0];

  disp_state_e             state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [NIBBLE_W-1:0]     dig_q, dig_d;
  logic                    ack_q, ack_d;
  logic                    frame_q, frame_d;
  logic [DATA_W-1:0]       staging_q, staging_d;
  logic [DATA_W-1:0]       shadow_q, shadow_d;
  logic                    pending_q, pending_d;

  logic                    cnt_load;
  logic [CNT_W-1:0]        cnt_val;
  logic                    cnt_done;
  logic                    advance;
  logic                    commit_win;
  logic [NUM_DIGITS-1:0]   lz_dark;
`ifdef DISP_LZ_BLANK_EN
  logic                    zero_run;
`endif

  disp_tick_cnt #(
    .W (CNT_W)
  ) u_tick_cnt (
    .clk      (CLK),
    .rst      (RST),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    staging_d  = staging_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    ack_d      = 1'b0;
    frame_d    = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    advance    = 1'b0;
    commit_win = (state_q == IDLE);

    if (!EN) begin
      state_d  = IDLE;
      sel_d    = '0;
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SHOW;
          sel_d    = '0;
          cnt_load = 1'b1;
          cnt_val  = SHOW_LEN;
        end
        SHOW: begin
          if (cnt_done) begin
            if (DEAD_CYC == 0) begin
              advance = 1'b1;
            end else begin
              state_d  = BLANK;
              cnt_load = 1'b1;
              cnt_val  = DEAD_LEN;
            end
          end
        end
        BLANK: begin
          if (cnt_done) begin
            advance = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          sel_d   = '0;
        end
      endcase
    end

    // Advance is the last cycle of a digit slot; the 3->0 step is the frame wrap.
    if (advance) begin
      state_d  = SHOW;
      cnt_load = 1'b1;
      cnt_val  = SHOW_LEN;
      if (sel_q == LAST_SEL) begin
        sel_d      = '0;
        frame_d    = 1'b1;
        commit_win = 1'b1;
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end

    if (commit_win && (LOAD || pending_q)) begin
      shadow_d  = LOAD ? D_IN : staging_q;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end else if (LOAD) begin
      staging_d = D_IN;
      pending_d = 1'b1;
    end

    dig_d = shadow_d[NIBBLE_W-1:0];
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (sel_d == SEL_W'(k)) begin
        dig_d = shadow_d[k*NIBBLE_W +: NIBBLE_W];
      end
    end

    lz_dark = '0;
`ifdef DISP_LZ_BLANK_EN
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_run   = zero_run & (shadow_d[k*NIBBLE_W +: NIBBLE_W] == '0);
      lz_dark[k] = zero_run;
    end
`endif

    an_d = AN_OFF;
    if (state_d == SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (sel_d == SEL_W'(k)) begin
          an_d[k] = lz_dark[k];
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      an_q      <= AN_OFF;
      dig_q     <= '0;
      ack_q     <= 1'b0;
      frame_q   <= 1'b0;
      staging_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      an_q      <= an_d;
      dig_q     <= dig_d;
      ack_q     <= ack_d;
      frame_q   <= frame_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
    end
  end

  assign SEL      = sel_q;
  assign AN       = an_q;
  assign DIG      = dig_q;
  assign LOAD_ACK = ack_q;
  assign FRAME    = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with a time-based reference model.
module tb_disp_scan_ctrl;

  localparam int CLK_DIV    = 4;
  localparam int DEAD_CYC   = 2;
  localparam int NUM_DIGITS = 4;
  localparam int PERIOD     = CLK_DIV + DEAD_CYC;
  localparam int FRAME_LEN  = PERIOD * NUM_DIGITS;

  logic        CLK  = 1'b0;
  logic        RST  = 1'b1;
  logic        EN   = 1'b0;
  logic        LOAD = 1'b0;
  logic [15:0] D_IN = '0;
  logic        LOAD_ACK;
  logic [1:0]  SEL;
  logic [3:0]  AN;
  logic [3:0]  DIG;
  logic        FRAME;

  int checks   = 0;
  int failures = 0;

  // Reference model: scan position is just the cycle index within the frame.
  bit          m_run    = 1'b0;
  int          m_t      = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_stage  = '0;
  bit          m_pend   = 1'b0;
  bit          m_wrap;
  bit          m_win;
  int          m_d;
  bit          m_lit;
  logic [3:0]  e_an     = 4'hF;
  logic [1:0]  e_sel    = '0;
  logic [3:0]  e_dig    = '0;
  logic        e_ack    = 1'b0;
  logic        e_frame  = 1'b0;

  always #5 CLK = ~CLK;

  disp_scan_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .DEAD_CYC   (DEAD_CYC),
    .NUM_DIGITS (NUM_DIGITS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .D_IN     (D_IN),
    .LOAD     (LOAD),
    .LOAD_ACK (LOAD_ACK),
    .SEL      (SEL),
    .AN       (AN),
    .DIG      (DIG),
    .FRAME    (FRAME)
  );

  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] s);
    logic [3:0] r;
    r = v[4*s +: 4];
    return r;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_run = 1'b0; m_t = 0; m_shadow = '0; m_stage = '0; m_pend = 1'b0;
      e_ack = 1'b0; e_frame = 1'b0;
    end else begin
      m_wrap = m_run && EN && (m_t == FRAME_LEN - 1);
      m_win  = !m_run || m_wrap;
      e_ack  = 1'b0;
      if (m_win && (LOAD || m_pend)) begin
        m_shadow = LOAD ? D_IN : m_stage;
        m_pend   = 1'b0;
        e_ack    = 1'b1;
      end else if (LOAD) begin
        m_stage = D_IN;
        m_pend  = 1'b1;
      end
      e_frame = m_wrap;
      if (!EN) begin
        m_run = 1'b0; m_t = 0;
      end else if (!m_run) begin
        m_run = 1'b1; m_t = 0;
      end else begin
        m_t = (m_t + 1) % FRAME_LEN;
      end
    end
    if (m_run) begin
      m_d   = m_t / PERIOD;
      m_lit = (m_t % PERIOD) < CLK_DIV;
`ifdef DISP_LZ_BLANK_EN
      m_lit = m_lit && (m_d == 0 || (m_shadow >> (4 * m_d)) != 16'h0);
`endif
      e_sel = 2'(m_d);
      e_an  = m_lit ? ~(4'b0001 << m_d) : 4'hF;
      e_dig = m_shadow[4*m_d +: 4];
    end else begin
      e_sel = '0;
      e_an  = 4'hF;
      e_dig = m_shadow[3:0];
    end
  end

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0; D_IN = '0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({AN, SEL, DIG, LOAD_ACK, FRAME} !== {4'hF, 2'd0, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_vals got an=%b sel=%0d dig=%h ack=%b frame=%b want an=1111 sel=0 dig=0 ack=0 frame=0",
               AN, SEL, DIG, LOAD_ACK, FRAME);
    end
    RST = 1'b0;
    repeat (50) begin
      @(negedge CLK);
      checks++;
      if (AN !== 4'hF || SEL !== 2'd0 || DIG !== 4'h0 || FRAME !== 1'b0) begin
        failures++;
        $display("FAIL idle_hold got an=%b sel=%0d dig=%h frame=%b want an=1111 sel=0 dig=0 frame=0",
                 AN, SEL, DIG, FRAME);
      end
    end
  endtask

  task automatic test_scan_order();
    logic [3:0] run_an[$];
    int         run_len[$];
    int         frame_at[$];
    logic [3:0] cur_an;
    int         cur_len;
    logic [3:0] exp_an[8]  = '{4'b1110, 4'b1111, 4'b1101, 4'b1111,
                               4'b1011, 4'b1111, 4'b0111, 4'b1111};
    int         exp_len[8] = '{4, 2, 4, 2, 4, 2, 4, 2};
    cur_an = 4'hF; cur_len = 0;
    D_IN = 16'h4321; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    checks++;
    if (LOAD_ACK !== 1'b1 || DIG !== 4'h1) begin
      failures++;
      $display("FAIL idle_commit got ack=%b dig=%h want ack=1 dig=1", LOAD_ACK, DIG);
    end
    EN = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      checks++;
      if ({AN, SEL, DIG, LOAD_ACK, FRAME} !== {e_an, e_sel, e_dig, e_ack, e_frame}) begin
        failures++;
        $display("FAIL scan_model i=%0d got an=%b sel=%0d dig=%h ack=%b fr=%b want an=%b sel=%0d dig=%h ack=%b fr=%b",
                 i, AN, SEL, DIG, LOAD_ACK, FRAME, e_an, e_sel, e_dig, e_ack, e_frame);
      end
      checks++;
      if (DIG !== {2'b00, SEL} + 4'd1) begin
        failures++;
        $display("FAIL dig_align i=%0d got dig=%h sel=%0d want dig=%0d", i, DIG, SEL, SEL + 1);
      end
      if (FRAME === 1'b1) frame_at.push_back(i);
      if (i == 0) begin
        cur_an = AN; cur_len = 1;
      end else if (AN === cur_an) begin
        cur_len++;
      end else begin
        run_an.push_back(cur_an); run_len.push_back(cur_len);
        cur_an = AN; cur_len = 1;
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (run_an.size() <= k || run_an[k] !== exp_an[k] || run_len[k] != exp_len[k]) begin
        failures++;
        $display("FAIL an_seq k=%0d got an=%b len=%0d want an=%b len=%0d", k,
                 (run_an.size() > k) ? run_an[k] : 4'hx, (run_len.size() > k) ? run_len[k] : -1,
                 exp_an[k], exp_len[k]);
      end
    end
    checks++;
    if (frame_at.size() != 2 || frame_at[0] != 24 || frame_at[1] != 48) begin
      failures++;
      $display("FAIL frame_spacing got count=%0d first=%0d want frames at 24 and 48",
               frame_at.size(), (frame_at.size() > 0) ? frame_at[0] : -1);
    end
  endtask

  task automatic test_deferred_load();
    int n;
    n = 0;
    while (SEL !== 2'd1 && n < 100) begin @(negedge CLK); n++; end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL wait_sel1 got timeout want sel=1"); end
    D_IN = 16'hABCD; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    n = 0;
    while (FRAME !== 1'b1 && n < 40) begin
      checks++;
      if (LOAD_ACK !== 1'b0 || DIG !== nib(16'h4321, SEL)) begin
        failures++;
        $display("FAIL defer_hold got ack=%b dig=%h want ack=0 dig=%h", LOAD_ACK, DIG, nib(16'h4321, SEL));
      end
      @(negedge CLK); n++;
    end
    checks++;
    if (n >= 40 || LOAD_ACK !== 1'b1 || DIG !== 4'hD || SEL !== 2'd0) begin
      failures++;
      $display("FAIL defer_wrap got ack=%b dig=%h sel=%0d want ack=1 dig=d sel=0", LOAD_ACK, DIG, SEL);
    end
    repeat (FRAME_LEN) begin
      @(negedge CLK);
      checks++;
      if (LOAD_ACK !== 1'b0 || DIG !== nib(16'hABCD, SEL)) begin
        failures++;
        $display("FAIL defer_new got ack=%b dig=%h want ack=0 dig=%h", LOAD_ACK, DIG, nib(16'hABCD, SEL));
      end
    end
  endtask

  task automatic test_collision();
    int n;
    int acks;
    acks = 0;
    n = 0;
    while (SEL !== 2'd1 && n < 100) begin @(negedge CLK); n++; end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL wait_sel1_col got timeout want sel=1"); end
    D_IN = 16'h1111; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    n = 0;
    while (!(m_run && m_t == FRAME_LEN - 1) && n < 40) begin
      if (LOAD_ACK === 1'b1) acks++;
      @(negedge CLK); n++;
    end
    checks++;
    if (n >= 40) begin failures++; $display("FAIL wait_wrap got timeout want last frame cycle"); end
    D_IN = 16'h2222; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    if (LOAD_ACK === 1'b1) acks++;
    checks++;
    if (LOAD_ACK !== 1'b1 || FRAME !== 1'b1 || DIG !== 4'h2) begin
      failures++;
      $display("FAIL col_wrap got ack=%b frame=%b dig=%h want ack=1 frame=1 dig=2", LOAD_ACK, FRAME, DIG);
    end
    repeat (FRAME_LEN + 4) begin
      @(negedge CLK);
      if (LOAD_ACK === 1'b1) acks++;
      checks++;
      if (DIG !== 4'h2) begin
        failures++;
        $display("FAIL col_shadow got dig=%h want 2", DIG);
      end
    end
    checks++;
    if (acks != 1) begin
      failures++;
      $display("FAIL col_ack_count got %0d want 1", acks);
    end
  endtask

  task automatic test_en_drop();
    int n;
    n = 0;
    while (!(SEL === 2'd2 && AN !== 4'hF) && n < 100) begin @(negedge CLK); n++; end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL wait_sel2 got timeout want sel=2 lit"); end
    EN = 1'b0;
    @(negedge CLK);
    checks++;
    if (AN !== 4'hF || SEL !== 2'd0 || FRAME !== 1'b0) begin
      failures++;
      $display("FAIL en_drop got an=%b sel=%0d frame=%b want an=1111 sel=0 frame=0", AN, SEL, FRAME);
    end
    EN = 1'b1;
    for (int i = 0; i < CLK_DIV; i++) begin
      @(negedge CLK);
      checks++;
      if (AN !== 4'b1110 || SEL !== 2'd0) begin
        failures++;
        $display("FAIL reenable_show i=%0d got an=%b sel=%0d want an=1110 sel=0", i, AN, SEL);
      end
    end
    @(negedge CLK);
    checks++;
    if (AN !== 4'hF || SEL !== 2'd0) begin
      failures++;
      $display("FAIL reenable_blank got an=%b sel=%0d want an=1111 sel=0", AN, SEL);
    end
  endtask

  task automatic test_reset_pending();
    int n;
    n = 0;
    while (SEL !== 2'd1 && n < 100) begin @(negedge CLK); n++; end
    checks++;
    if (n >= 100) begin failures++; $display("FAIL wait_sel1_rst got timeout want sel=1"); end
    D_IN = 16'h9876; LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    #2 RST = 1'b1;
    #1;
    checks++;
    if ({AN, SEL, DIG, LOAD_ACK, FRAME} !== {4'hF, 2'd0, 4'h0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got an=%b sel=%0d dig=%h ack=%b frame=%b want an=1111 sel=0 dig=0 ack=0 frame=0",
               AN, SEL, DIG, LOAD_ACK, FRAME);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (FRAME_LEN + 6) begin
      @(negedge CLK);
      checks++;
      if (LOAD_ACK !== 1'b0 || DIG !== 4'h0) begin
        failures++;
        $display("FAIL rst_discard got ack=%b dig=%h want ack=0 dig=0", LOAD_ACK, DIG);
      end
    end
  endtask

  task automatic test_lz_blank();
    logic [15:0] pat[2] = '{16'h0050, 16'h0000};
    int          lit[4];
`ifdef DISP_LZ_BLANK_EN
    int          want[2][4] = '{'{4, 4, 0, 0}, '{4, 0, 0, 0}};
`else
    int          want[2][4] = '{'{4, 4, 4, 4}, '{4, 4, 4, 4}};
`endif
    for (int p = 0; p < 2; p++) begin
      EN = 1'b0; D_IN = pat[p]; LOAD = 1'b1;
      @(negedge CLK);
      LOAD = 1'b0;
      @(negedge CLK);
      EN = 1'b1;
      for (int k = 0; k < 4; k++) lit[k] = 0;
      for (int i = 0; i < FRAME_LEN; i++) begin
        @(negedge CLK);
        for (int k = 0; k < 4; k++) if (AN[k] === 1'b0) lit[k]++;
        checks++;
        if ({AN, SEL, DIG} !== {e_an, e_sel, e_dig}) begin
          failures++;
          $display("FAIL lz_model got an=%b sel=%0d dig=%h want an=%b sel=%0d dig=%h",
                   AN, SEL, DIG, e_an, e_sel, e_dig);
        end
      end
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (lit[k] != want[p][k]) begin
          failures++;
          $display("FAIL lz_lit pat=%h digit=%0d got %0d lit cycles want %0d", pat[p], k, lit[k], want[p][k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK);
      checks++;
      if ({AN, SEL, DIG, LOAD_ACK, FRAME} !== {e_an, e_sel, e_dig, e_ack, e_frame}) begin
        failures++;
        $display("FAIL rand_model i=%0d got an=%b sel=%0d dig=%h ack=%b fr=%b want an=%b sel=%0d dig=%h ack=%b fr=%b",
                 i, AN, SEL, DIG, LOAD_ACK, FRAME, e_an, e_sel, e_dig, e_ack, e_frame);
      end
      if ($urandom_range(0, 99) < 3) EN = ~EN;
      LOAD = ($urandom_range(0, 99) < 8);
      v = 16'($urandom);
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 1) == 0) v[4*k +: 4] = 4'h0;
      D_IN = v;
    end
    LOAD = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_deferred_load();
    test_collision();
    test_en_drop();
    test_reset_pending();
    test_lz_blank();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/disp_scan_ctrl.md
Name: disp_scan_ctrl

Overview:
- Time-multiplexed scan controller for the 7-segment display path.
- Cycles the digit-select code (SEL) and active-low anode enables across NUM_DIGITS digits, with a dead-time gap between digits to suppress ghosting.
- Holds a double-buffered copy of the display nibbles and presents the selected nibble on DIG; the buffer updates only at a frame boundary, so digits never tear mid-frame.
- Sits between the value-producing logic and the digit mux / segment decoder.

Parameters:
- CLK_DIV, 4096: clock cycles each digit is lit; must be ≥1.
- DEAD_CYC, 16: all-off cycles between digits; 0 removes the gap.
- NUM_DIGITS, 4: digits scanned; legal range 2..4.

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset, asynchronous, active-high.
- EN  in  1  scan enable.
- D_IN  in  4*NUM_DIGITS  display nibbles; digit k = D_IN[4k+3:4k].
- LOAD  in  1  request to update the display buffer from D_IN.
- LOAD_ACK  out  1  one-cycle pulse when a staged value is committed to the display buffer.
- SEL  out  2  current digit index, drives the digit mux select.
- AN  out  NUM_DIGITS  anode enables, active-low.
- DIG  out  4  nibble of the current digit.
- FRAME  out  1  one-cycle pulse at each frame wrap.

Behaviour:
- Clock and reset: one clock (CLK). RST is asynchronous, active-high.
- Reset values: state=IDLE, SEL=0, AN=all 1, DIG=0, LOAD_ACK=0, FRAME=0, counter=0, staging=0, shadow=0, pending=0.
- All outputs are registered.
- FSM states:
  - IDLE: AN all 1, SEL=0, counter held at 0. Leaves to SHOW on EN=1.
  - SHOW: AN[SEL]=0, all other AN=1. Counts CLK_DIV cycles, then goes to BLANK (or directly to ADVANCE when DEAD_CYC=0).
  - BLANK: AN all 1. Counts DEAD_CYC cycles, then ADVANCE.
  - ADVANCE: single-cycle action folded into the last BLANK/SHOW cycle, not a separate state. SEL <= (SEL==NUM_DIGITS-1) ? 0 : SEL+1, then re-enter SHOW.
- Timing: digit period = CLK_DIV+DEAD_CYC cycles; frame = NUM_DIGITS × digit period.
- EN deassert: in any state, next cycle goes to IDLE with AN all 1 and SEL=0. Re-enable always restarts at digit 0 with a full CLK_DIV count.
- Counter width: $clog2(max(CLK_DIV,DEAD_CYC)+1). No wrap-around beyond the terminal compare.
- DIG = shadow nibble indexed by SEL, registered in the same cycle SEL is registered, so DIG and SEL stay aligned.
- Load handshake:
  - LOAD=1 copies D_IN into staging and sets pending. Repeated LOADs overwrite staging; last one wins.
  - Commit occurs on the frame-wrap cycle (SEL going NUM_DIGITS-1 → 0), or on any cycle while in IDLE: shadow <= staging, pending cleared, LOAD_ACK=1 for one cycle. Exactly one ACK per commit, regardless of how many LOADs preceded it.
  - LOAD on the same cycle as a commit: D_IN bypasses staging into shadow and is acknowledged in that cycle.
- FRAME pulses on the wrap cycle whether or not a commit occurs. No FRAME is generated in IDLE.
- Reset mid-frame: everything returns to reset values immediately. A pending load is discarded with no ACK.

Optional Feature:
- Macro: DISP_LZ_BLANK_EN.
- Defined: leading-zero suppression. During SHOW, AN[SEL] stays 1 when SEL>0 and shadow digits SEL..NUM_DIGITS-1 are all zero. Digit 0 is always lit. Scan timing, SEL and DIG are unchanged.
- Undefined: every digit is lit in its SHOW slot.

Decomposition:
- Shared package disp_pkg holds:
  - state typedef {IDLE, SHOW, BLANK}
  - NIBBLE_W=4
  - SEL_W=2
  - ANODE_OFF constant (all ones)
- One natural sub-module: disp_tick_cnt (loadable terminal-count down-counter with done flag), instantiated once and reloaded with CLK_DIV or DEAD_CYC per state.
- The FSM, buffering and handshake stay in the top level.

Test Plan:
Bench parameters for all scenarios: CLK_DIV=4, DEAD_CYC=2, NUM_DIGITS=4.
- Reset/idle: RST=1 then released with EN=0 → AN=4'b1111, SEL=0, DIG=0, no FRAME for 50 cycles.
- Scan order: EN=1, D_IN=16'h4321 loaded in IDLE → AN sequence 1110,1111,1101,1111,1011,1111,0111,1111 with segments of 4/2/4/2… cycles; DIG 1,2,3,4 aligned with SEL 0..3; FRAME every 24 cycles.
- Deferred load: mid-frame LOAD with D_IN=16'hABCD → digits keep 4321 until the wrap; LOAD_ACK and FRAME both pulse on the wrap cycle; next frame shows D,C,B,A.
- Collision/overwrite: LOAD=16'h1111 mid-frame, then LOAD=16'h2222 exactly on the wrap cycle → shadow=16'h2222, one LOAD_ACK, 16'h1111 never displayed.
- EN drop/reset mid-frame: EN=0 at SEL=2 → next cycle AN=1111, SEL=0; re-enable starts at digit 0 with a full 4-cycle SHOW. RST pulse while pending → no ACK, shadow=0.
- DISP_LZ_BLANK_EN defined: shadow=16'h0050 → digits 3 and 2 stay dark, digits 1 and 0 lit. shadow=16'h0000 → only digit 0 lit.
